// File: rtl/ans_ht_ltf_rx_collect.sv
// rtl/ans_ht_ltf_rx_collect.sv - HT-LTF receive collector: CP strip, multi-symbol average, stream out
//
// Strips the cyclic prefix from each 80-sample HT-LTF symbol, averages the
// 64 useful samples over 1, 2 or 4 symbols and streams the 64 averaged
// samples to the FFT / channel-estimation stage.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   sample_in_strobe  sample_in valid this cycle
//   sample_in         {I[15:0], Q[15:0]} two's complement
//   ltf_start         first CP sample of the first HT-LTF symbol (with strobe)
//   ltf_log2          symbols to average as log2 (3 behaves as 2), latched on start
//   out_tdata         averaged sample {I, Q}
//   out_tvalid        out_tdata valid
//   out_tready        downstream accepts
//   out_tlast         high with the 64th output sample
//   busy              not idle
//   overrun           sticky error: strobe during output or unexpected ltf_start

module ans_ht_ltf_rx_collect #(
    parameter int CP_LEN  = 16,
    parameter int SYM_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_in_strobe,
    input  logic [31:0] sample_in,
    input  logic        ltf_start,
    input  logic [1:0]  ltf_log2,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic        busy,
    output logic        overrun
);

    localparam int SYM_TOT = CP_LEN + SYM_LEN;
    localparam int IDX_W   = $clog2(SYM_TOT);
    localparam int OUT_W   = $clog2(SYM_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP_CP,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0] sample_idx;
    logic [1:0]       sym_cnt;
    logic [1:0]       avg_log2;
    logic [OUT_W-1:0] out_idx;

    // 18 bits hold the sum of four full-scale 16-bit samples without overflow.
    logic signed [17:0] acc_i [SYM_LEN];
    logic signed [17:0] acc_q [SYM_LEN];

    logic               start_hit;
    logic               cp_done;
    logic               last_useful;
    logic               more_syms;
    logic               out_fire;
    logic               out_final;
    logic [OUT_W-1:0]   wr_idx;
    logic signed [17:0] ext_i;
    logic signed [17:0] ext_q;
    logic signed [17:0] rd_i;
    logic signed [17:0] rd_q;
    logic signed [15:0] avg_i;
    logic signed [15:0] avg_q;

    assign start_hit   = sample_in_strobe && ltf_start;
    assign cp_done     = (sample_idx == IDX_W'(CP_LEN - 1));
    assign last_useful = (sample_idx == IDX_W'(SYM_TOT - 1));
    // Compare in 3 bits so 2^2 = 4 is representable.
    assign more_syms   = (({1'b0, sym_cnt} + 3'd1) < (3'd1 << avg_log2));
    assign out_fire    = (state == S_OUTPUT) && out_tready;
    assign out_final   = out_fire && (out_idx == OUT_W'(SYM_LEN - 1));
    assign wr_idx      = OUT_W'(sample_idx - IDX_W'(CP_LEN));

    assign ext_i = {{2{sample_in[31]}}, sample_in[31:16]};
    assign ext_q = {{2{sample_in[15]}}, sample_in[15:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_hit) begin
                    state_nx = S_SKIP_CP;
                end
            end
            S_SKIP_CP: begin
                if (sample_in_strobe && cp_done) begin
                    state_nx = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sample_in_strobe && last_useful) begin
                    state_nx = more_syms ? S_SKIP_CP : S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_tvalid = 1'b1;
                out_tlast  = (out_idx == OUT_W'(SYM_LEN - 1));
                if (out_final) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and latched averaging depth
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_idx <= '0;
            sym_cnt    <= '0;
            avg_log2   <= '0;
            out_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_hit) begin
                        avg_log2   <= (ltf_log2 == 2'd3) ? 2'd2 : ltf_log2;
                        // The start sample itself is CP sample 0.
                        sample_idx <= IDX_W'(1);
                        sym_cnt    <= '0;
                        out_idx    <= '0;
                    end
                end
                S_SKIP_CP: begin
                    if (sample_in_strobe) begin
                        sample_idx <= sample_idx + IDX_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (sample_in_strobe) begin
                        if (last_useful) begin
                            sample_idx <= '0;
                            if (more_syms) begin
                                sym_cnt <= sym_cnt + 2'd1;
                            end else begin
                                out_idx <= '0;
                            end
                        end else begin
                            sample_idx <= sample_idx + IDX_W'(1);
                        end
                    end
                end
                S_OUTPUT: begin
                    if (out_fire) begin
                        out_idx <= out_final ? '0 : out_idx + OUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accumulator buffer; symbol 0 overwrites, so no reset is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && (state == S_ACCUM) && sample_in_strobe) begin
            if (sym_cnt == 2'd0) begin
                acc_i[wr_idx] <= ext_i;
                acc_q[wr_idx] <= ext_q;
            end else begin
                acc_i[wr_idx] <= acc_i[wr_idx] + ext_i;
                acc_q[wr_idx] <= acc_q[wr_idx] + ext_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if ((sample_in_strobe && (state == S_OUTPUT)) ||
                     (start_hit && (state != S_IDLE))) begin
            overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output data: registered buffer and index only, so no glitches at
    // the edge. Arithmetic shift floors; the result always fits 16 bits.
    // ------------------------------------------------------------------
    assign rd_i  = acc_i[out_idx];
    assign rd_q  = acc_q[out_idx];
    assign avg_i = 16'(rd_i >>> avg_log2);
    assign avg_q = 16'(rd_q >>> avg_log2);

    assign out_tdata = (state == S_OUTPUT) ? {avg_i, avg_q} : 32'd0;

endmodule

// File: tb/tb_ans_ht_ltf_rx_collect.sv
// tb/tb_ans_ht_ltf_rx_collect.sv - self-checking bench for ans_ht_ltf_rx_collect
module tb_ans_ht_ltf_rx_collect;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_in_strobe = 1'b0;
    logic [31:0] sample_in = '0;
    logic        ltf_start = 1'b0;
    logic [1:0]  ltf_log2 = '0;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic        out_tlast;
    logic        busy;
    logic        overrun;

    ans_ht_ltf_rx_collect dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in_strobe (sample_in_strobe),
        .sample_in        (sample_in),
        .ltf_start        (ltf_start),
        .ltf_log2         (ltf_log2),
        .out_tdata        (out_tdata),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tlast        (out_tlast),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       lg;
        logic [3:0][15:0] si;
        logic [3:0][15:0] sq;
        logic [15:0]      ei;
        logic [15:0]      eq;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] smp [0:3][0:79];
    logic [32:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_xfer = 0;
    int          ready_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input int lg, input int i0, input int q0, input int i1, input int q1,
                                input int i2, input int q2, input int i3, input int q3,
                                input int ei, input int eq);
        vec_t v;
        v.lg = 2'(lg);
        v.si[0] = 16'(i0); v.sq[0] = 16'(q0);
        v.si[1] = 16'(i1); v.sq[1] = 16'(q1);
        v.si[2] = 16'(i2); v.sq[2] = 16'(q2);
        v.si[3] = 16'(i3); v.sq[3] = 16'(q3);
        v.ei = 16'(ei); v.eq = 16'(eq);
        return v;
    endfunction

    // Downstream ready, changed well away from both edges.
    always @(posedge clk) begin
        #2;
        out_tready = ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard monitor: a transfer happens at the next posedge if valid&&ready now.
    always @(negedge clk) begin
        if (!reset && out_tvalid && out_tready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL extra_xfer: got data %h with no expected sample", out_tdata);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("out_sample", {31'b0, out_tlast, out_tdata}, {31'b0, e});
            end
        end
    end

    task automatic put_sample(input logic [31:0] d, input logic st, input int gap_pct);
        while ($urandom_range(0, 99) < gap_pct) begin
            sample_in_strobe = 1'b0;
            @(posedge clk); #1;
        end
        sample_in_strobe = 1'b1;
        sample_in        = d;
        ltf_start        = st;
        @(posedge clk); #1;
        sample_in_strobe = 1'b0;
        ltf_start        = 1'b0;
    endtask

    task automatic push_model(input logic [1:0] lg);
        int eff;
        eff = (lg == 2'd3) ? 2 : int'(lg);
        for (int k = 0; k < 64; k++) begin
            int si = 0;
            int sq = 0;
            for (int s = 0; s < (1 << eff); s++) begin
                si += int'($signed(smp[s][k+16][31:16]));
                sq += int'($signed(smp[s][k+16][15:0]));
            end
            sb.push_back({(k == 63), 16'(si >>> eff), 16'(sq >>> eff)});
        end
    endtask

    task automatic fill_random();
        for (int s = 0; s < 4; s++)
            for (int n = 0; n < 80; n++) smp[s][n] = $urandom;
    endtask

    task automatic drive_run(input logic [1:0] lg, input int err_at, input int gap_pct);
        int nsym;
        nsym = 1 << ((lg == 2'd3) ? 2 : int'(lg));
        ltf_log2 = lg;
        for (int s = 0; s < nsym; s++) begin
            for (int n = 0; n < 80; n++) begin
                logic st;
                st = ((s == 0) && (n == 0)) || ((s * 80 + n) == err_at);
                if ((s == nsym - 1) && (n == 79)) check("tvalid_before_last", 64'(out_tvalid), 64'(0));
                put_sample(smp[s][n], st, gap_pct);
            end
        end
        check("tvalid_rise", 64'(out_tvalid), 64'(1));
    endtask

    task automatic wait_drain();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sb.size() != 0 || busy) && t < 4000);
        check("drain_done", 64'(sb.size() == 0 && !busy), 64'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x0;
        tbl[0] = mk(1,   100, -100,   200, -201,     0,      0,     0,      0,   150,  -151);
        tbl[1] = mk(2, 32767,-32768, 32767,-32768, 32767,-32768, 32767,-32768, 32767,-32768);
        tbl[2] = mk(3, 32767,-32768, 32767,-32768, 32767,-32768, 32767,-32768, 32767,-32768);
        tbl[3] = mk(0,     5,   -7,     0,    0,     0,      0,     0,      0,     5,    -7);
        tbl[4] = mk(2,     1,   -1,     2,   -2,     3,     -3,     5,     -5,     2,    -3);
        tbl[5] = mk(1,    -3,    3,     0,    0,     0,      0,     0,      0,    -2,     1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_tvalid",  64'(out_tvalid), 64'(0));
        check("rst_tlast",   64'(out_tlast),  64'(0));
        check("rst_busy",    64'(busy),       64'(0));
        check("rst_overrun", 64'(overrun),    64'(0));
        check("rst_tdata",   64'(out_tdata),  64'(0));

        // Strobes without ltf_start in IDLE are ignored.
        put_sample(32'h1234_5678, 1'b0, 0);
        put_sample(32'h0bad_f00d, 1'b0, 0);
        check("idle_ignore_busy", 64'(busy), 64'(0));

        // Ramp, single symbol, back-to-back, ready always high.
        for (int n = 0; n < 80; n++) smp[0][n] = {16'(n), 16'(-n)};
        for (int k = 0; k < 64; k++) sb.push_back({(k == 63), 16'(k + 16), 16'(-(k + 16))});
        x0 = n_xfer;
        drive_run(2'd0, -1, 0);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(out_tvalid && out_tready && out_tlast) && t < 200);
            @(posedge clk); #1;
            check("busy_fall", 64'(busy), 64'(0));
            check("tvalid_fall", 64'(out_tvalid), 64'(0));
            check("ramp_xfers", 64'(n_xfer - x0), 64'(64));
        end

        // Table-driven averaging with CP garbage, input gaps and backpressure.
        ready_pct = 60;
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 4; s++)
                for (int n = 0; n < 80; n++)
                    smp[s][n] = (n < 16) ? $urandom : {tbl[i].si[s], tbl[i].sq[s]};
            for (int k = 0; k < 64; k++) sb.push_back({(k == 63), tbl[i].ei, tbl[i].eq});
            drive_run(tbl[i].lg, -1, 20);
            wait_drain();
        end

        // Random data, ~30% ready, random input gaps.
        ready_pct = 30;
        for (int r = 0; r < 3; r++) begin
            logic [1:0] lg;
            lg = 2'($urandom_range(0, 3));
            fill_random();
            push_model(lg);
            x0 = n_xfer;
            drive_run(lg, -1, 40);
            wait_drain();
            check("rand_xfers", 64'(n_xfer - x0), 64'(64));
        end
        check("no_overrun_clean", 64'(overrun), 64'(0));

        // Second ltf_start during ACCUM: ignored, overrun sticky until reset.
        ready_pct = 100;
        for (int n = 0; n < 80; n++) smp[0][n] = {16'(n * 3), 16'(7 - n)};
        push_model(2'd0);
        drive_run(2'd0, 30, 0);
        wait_drain();
        check("ovr_accum_sticky", 64'(overrun), 64'(1));
        pulse_reset();
        check("ovr_cleared", 64'(overrun), 64'(0));

        // Strobe during OUTPUT: dropped, output held, overrun set.
        ready_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        fill_random();
        push_model(2'd1);
        drive_run(2'd1, -1, 0);
        check("ovr_before_drop", 64'(overrun), 64'(0));
        put_sample(32'hdead_beef, 1'b0, 0);
        check("ovr_output", 64'(overrun), 64'(1));
        check("held_tdata", 64'(out_tdata), 64'(sb[0][31:0]));
        check("held_tvalid", 64'(out_tvalid), 64'(1));
        ready_pct = 100;
        wait_drain();
        check("ovr_output_sticky", 64'(overrun), 64'(1));
        pulse_reset();

        // Reset mid-ACCUM at sample 40 of the second symbol, then a clean run.
        fill_random();
        ltf_log2 = 2'd2;
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < ((s == 0) ? 80 : 41); n++)
                put_sample(smp[s][n], (s == 0) && (n == 0), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",   64'(busy),       64'(0));
        check("midrst_tvalid", 64'(out_tvalid), 64'(0));
        check("midrst_tdata",  64'(out_tdata),  64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        fill_random();
        push_model(2'd0);
        drive_run(2'd0, -1, 0);
        wait_drain();
        check("final_overrun", 64'(overrun), 64'(0));
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ans_ht_ltf_rx_collect.md
# ans_ht_ltf_rx_collect

Receive-side counterpart of the TX HT-LTF time-domain source. The block takes the 80-sample-per-symbol HT-LTF stream arriving from the RX front end and discards each 16-sample cyclic prefix. It averages the 64 useful samples over 1, 2 or 4 HT-LTF symbols and streams the 64 averaged time-domain samples to the downstream FFT/channel-estimation stage over a valid/ready handshake.

## Interface

Parameters:
- CP_LEN, 16, cyclic-prefix samples discarded per symbol.
- SYM_LEN, 64, useful samples kept per symbol; also the buffer depth.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high.
- sample_in_strobe  input  1  sample_in is valid this cycle.
- sample_in  input  32  I in [31:16], Q in [15:0], both 16-bit two's complement.
- ltf_start  input  1  marks the first CP sample of the first HT-LTF symbol; only meaningful while sample_in_strobe=1.
- ltf_log2  input  2  number of symbols to average, as log2: 0→1, 1→2, 2→4; 3 is treated as 2. Latched on start.
- out_tdata  output  32  averaged sample: I in [31:16], Q in [15:0].
- out_tvalid  output  1  out_tdata is valid.
- out_tready  input  1  downstream accepts the sample.
- out_tlast  output  1  high with the 64th output sample.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  sticky error flag; cleared only by reset.

## Operation

- Storage: 64-entry accumulator buffer, 18-bit signed I plus 18-bit signed Q per entry. Counters: sample index 0..79, symbol count 0..3, output index 0..63.
- State IDLE:
  - On sample_in_strobe && ltf_start: latch ltf_log2, set sample index=1 (the start sample is CP sample 0), symbol=0, go to SKIP_CP.
  - Strobes without ltf_start are ignored.
- State SKIP_CP: each strobe increments the sample index. The strobe that takes the index to 16 goes to ACCUM.
- State ACCUM: each strobe writes entry k = index−16.
  - Symbol 0: the entry is overwritten with the sign-extended sample.
  - Later symbols: the entry becomes the old entry plus the sign-extended sample, computed separately for I and Q.
  - At index 79: if symbol+1 < 2^log2, increment symbol, reset the index to 0 and return to SKIP_CP. Otherwise go to OUTPUT with output index=0.
- Between symbols, no ltf_start is expected. The sample after index 79 is CP sample 0 of the next symbol, and an ltf_start on it is ignored.
- State OUTPUT:
  - out_tvalid=1.
  - out_tdata = {entry.I >>> log2, entry.Q >>> log2}, each truncated to 16 bits. The shift is arithmetic, so it rounds toward −∞. No saturation is needed.
  - The output index advances on each out_tvalid && out_tready cycle. out_tlast = (output index==63).
  - The transfer at index 63 returns the block to IDLE.
- Overrun is set in two cases:
  - A sample_in_strobe occurs while in OUTPUT. The sample is dropped and the output is unaffected.
  - ltf_start is seen with a strobe in any state other than IDLE. It is ignored and the current symbol continues.
- Reset, including mid-operation: state=IDLE, all counters=0, out_tvalid=0, overrun=0. Buffer contents need no reset because symbol 0 overwrites them.

## Timing

- Reset values: out_tvalid=0, out_tlast=0, busy=0, overrun=0, out_tdata=0.
- Input samples may arrive back-to-back (one per cycle) or with arbitrary gaps. Only strobed cycles advance the counters.
- out_tvalid rises in the cycle after the edge that accepts the final sample (the 80·2^log2-th).
- The output phase holds out_tdata/out_tvalid/out_tlast stable while out_tready=0. One sample per cycle is transferred while out_tready=1, so the minimum output phase is 64 cycles.
- busy falls in the cycle after the tlast transfer.
- A new ltf_start is accepted in that same cycle (IDLE) or later.
- out_tdata is a combinational read of the registered buffer and index, and is glitch-free at clock edges.

## Test plan

- Single symbol, log2=0, back-to-back samples with sample n={n,−n}, n=0..79 → 64 outputs {16,−16}…{79,−79}. tlast only on the last output; out_tvalid rises 1 cycle after sample 79; busy falls after the final transfer.
- Two-symbol average, log2=1: symbol 1 samples all {100,−100}, symbol 2 all {200,−201} → all 64 outputs {150,−151}.
- Four-symbol average, log2=2, values {32767,−32768} every sample → outputs {32767,−32768}, with no overflow in the 18-bit accumulators. Repeat with log2=3 → identical to log2=2.
- Backpressure: random out_tready at about 30% duty and random strobe gaps on input → exactly 64 transfers in order, no duplicates or drops, tlast on the 64th.
- Error cases: a strobe during OUTPUT, and a second ltf_start during ACCUM → overrun=1 stays set. Output data is unchanged from the error-free expectation; only reset clears overrun.
- Reset asserted mid-ACCUM at sample 40 of symbol 1, then a clean single-symbol run → correct outputs, no residue from the aborted run.
